// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed 7-segment scanner with frame-aligned double buffering.
// Loads are staged and only reach the displayed shadow copy when the scan wraps 3->0.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic        pending,
  output logic [1:0]  sel,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int DW = $clog2(REFRESH_DIV);

  logic [DW-1:0] div_cnt;
  logic          step;
  logic          wrap;

  logic [15:0] stg_value;
  logic [3:0]  stg_dp;
  logic [3:0]  stg_blank;
  logic [15:0] sh_value;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_blank;

  logic [3:0] nib;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  assign step = (div_cnt == DW'(REFRESH_DIV - 1));
  assign wrap = step && (sel == 2'd3);

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    nib   = sh_value[{sel, 2'b00} +: 4];
    if (!sh_blank[sel]) begin
      an_d = ~(4'b0001 << sel);
      dp_d = ~sh_dp[sel];
      case (nib)
        4'h0: seg_d = 7'h40;
        4'h1: seg_d = 7'h79;
        4'h2: seg_d = 7'h24;
        4'h3: seg_d = 7'h30;
        4'h4: seg_d = 7'h19;
        4'h5: seg_d = 7'h12;
        4'h6: seg_d = 7'h02;
        4'h7: seg_d = 7'h78;
        4'h8: seg_d = 7'h00;
        4'h9: seg_d = 7'h10;
        4'hA: seg_d = 7'h08;
        4'hB: seg_d = 7'h03;
        4'hC: seg_d = 7'h46;
        4'hD: seg_d = 7'h21;
        4'hE: seg_d = 7'h06;
        default: seg_d = 7'h0E;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      sel        <= 2'd0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      stg_value  <= '0;
      stg_dp     <= '0;
      stg_blank  <= '0;
      sh_value   <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
    end else begin
      if (step) begin
        div_cnt <= '0;
        sel     <= sel + 2'd1;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      frame_tick <= wrap;

      // A load landing on the wrap cycle bypasses staging so it shows in the new frame.
      if (load && wrap) begin
        sh_value <= value;
        sh_dp    <= dp_en;
        sh_blank <= blank;
        pending  <= 1'b0;
      end else if (load) begin
        stg_value <= value;
        stg_dp    <= dp_en;
        stg_blank <= blank;
        pending   <= 1'b1;
      end else if (wrap && pending) begin
        sh_value <= stg_value;
        sh_dp    <= stg_dp;
        sh_blank <= stg_blank;
        pending  <= 1'b0;
      end

      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule
